cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 27 ++
 rtl/cdb_fifo.sv | 80 ++++++++
 rtl/cdb_arbiter.sv | 159 +++++++++++++++
 tb/tb_cdb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus: source encodings, default widths
// and the round-robin successor helper used by the arbiter.
package cdb_arbiter_pkg;

  localparam int TAG_W_DEF  = 4;
  localparam int DATA_W_DEF = 32;

  // Encoding of the broadcast source, also read by issue logic and reservation stations
  typedef enum logic [1:0] {
    CDB_NONE = 2'b00,
    CDB_ALU  = 2'b01,
    CDB_FPU  = 2'b10,
    CDB_LSU  = 2'b11
  } cdb_src_e;

  // Next source in the ALU -> FPU -> LSU -> ALU rotation; NONE restarts at ALU
  function automatic cdb_src_e rr_next(input cdb_src_e s);
    cdb_src_e n;
    case (s)
      CDB_ALU: n = CDB_FPU;
      CDB_FPU: n = CDB_LSU;
      default: n = CDB_ALU;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-source result FIFO. Ready/full come from the registered count only,
// so a full FIFO refuses a push even in a cycle where it is also popped.
// A synchronous flush empties it and overrides any push or pop that cycle.
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_data = mem_q[rd_ptr_q];

  // Pointer increment that wraps at DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for storage, pointers and occupancy
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State registers with asynchronous reset to empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three result sources (ALU, FPU, LSU) each feed a
// small FIFO, and a round-robin arbiter picks one non-empty head per cycle and
// registers it onto the single CDB broadcast port.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              fpu_valid,
  output logic              fpu_ready,
  input  logic [TAG_W-1:0]  fpu_tag,
  input  logic [DATA_W-1:0] fpu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [TAG_W-1:0]  lsu_tag,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              lsu_is_fp,
  output logic              cdb_valid,
  output logic [1:0]        cdb_src,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              cdb_is_fp
);

  localparam int ENTRY_W = TAG_W + DATA_W + 1;

  logic [ENTRY_W-1:0] alu_head, fpu_head, lsu_head, sel_entry;
  logic               alu_empty, fpu_empty, lsu_empty;
  logic               alu_full, fpu_full, lsu_full;
  cdb_src_e           grant_src;

  cdb_src_e          last_q, last_d;
  logic              cdb_valid_q, cdb_valid_d;
  cdb_src_e          cdb_src_q, cdb_src_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              cdb_is_fp_q, cdb_is_fp_d;

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_alu_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (alu_valid),
    .push_data ({alu_tag, alu_data, 1'b0}),
    .pop       (grant_src == CDB_ALU),
    .head_data (alu_head),
    .empty     (alu_empty),
    .full      (alu_full)
  );

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fpu_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (fpu_valid),
    .push_data ({fpu_tag, fpu_data, 1'b1}),
    .pop       (grant_src == CDB_FPU),
    .head_data (fpu_head),
    .empty     (fpu_empty),
    .full      (fpu_full)
  );

  cdb_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_lsu_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (lsu_valid),
    .push_data ({lsu_tag, lsu_data, lsu_is_fp}),
    .pop       (grant_src == CDB_LSU),
    .head_data (lsu_head),
    .empty     (lsu_empty),
    .full      (lsu_full)
  );

  assign alu_ready = !alu_full;
  assign fpu_ready = !fpu_full;
  assign lsu_ready = !lsu_full;

  // Round-robin scan starting just after the last granted source; flush suppresses any grant
  always_comb begin
    cdb_src_e cand;
    logic     hit;
    grant_src = CDB_NONE;
    cand      = rr_next(last_q);
    hit       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      case (cand)
        CDB_ALU: hit = !alu_empty;
        CDB_FPU: hit = !fpu_empty;
        CDB_LSU: hit = !lsu_empty;
        default: hit = 1'b0;
      endcase
      if ((grant_src == CDB_NONE) && hit) grant_src = cand;
      cand = rr_next(cand);
    end
    if (flush) grant_src = CDB_NONE;
  end

  // Select the head entry of the granted FIFO
  always_comb begin
    sel_entry = alu_head;
    case (grant_src)
      CDB_FPU: sel_entry = fpu_head;
      CDB_LSU: sel_entry = lsu_head;
      default: sel_entry = alu_head;
    endcase
  end

  // Next broadcast and pointer: payload holds on idle cycles, pointer moves only on a grant
  always_comb begin
    last_d      = last_q;
    cdb_valid_d = 1'b0;
    cdb_src_d   = CDB_NONE;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_is_fp_d = cdb_is_fp_q;
    if (grant_src != CDB_NONE) begin
      last_d      = grant_src;
      cdb_valid_d = 1'b1;
      cdb_src_d   = grant_src;
      {cdb_tag_d, cdb_data_d, cdb_is_fp_d} = sel_entry;
    end
  end

  // Output and pointer registers; reset leaves LSU as "last" so ALU wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q      <= CDB_LSU;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= CDB_NONE;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_is_fp_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_src_q   <= cdb_src_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_is_fp_q <= cdb_is_fp_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_src   = cdb_src_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_is_fp = cdb_is_fp_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cdb_arbiter;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              alu_valid = 1'b0, fpu_valid = 1'b0, lsu_valid = 1'b0;
  logic              alu_ready, fpu_ready, lsu_ready;
  logic [TAG_W-1:0]  alu_tag = '0, fpu_tag = '0, lsu_tag = '0;
  logic [DATA_W-1:0] alu_data = '0, fpu_data = '0, lsu_data = '0;
  logic              lsu_is_fp = 1'b0;
  logic              cdb_valid;
  logic [1:0]        cdb_src;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              cdb_is_fp;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_tag   (alu_tag),
    .alu_data  (alu_data),
    .fpu_valid (fpu_valid),
    .fpu_ready (fpu_ready),
    .fpu_tag   (fpu_tag),
    .fpu_data  (fpu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_tag   (lsu_tag),
    .lsu_data  (lsu_data),
    .lsu_is_fp (lsu_is_fp),
    .cdb_valid (cdb_valid),
    .cdb_src   (cdb_src),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_is_fp (cdb_is_fp)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] ad,
                               input logic fv, input logic [TAG_W-1:0] ft, input logic [DATA_W-1:0] fd,
                               input logic lv, input logic [TAG_W-1:0] lt, input logic [DATA_W-1:0] ld,
                               input logic lfp, input logic fl);
    alu_valid = av; alu_tag = at; alu_data = ad;
    fpu_valid = fv; fpu_tag = ft; fpu_data = fd;
    lsu_valid = lv; lsu_tag = lt; lsu_data = ld; lsu_is_fp = lfp;
    flush = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              fp;
  } entry_t;

  entry_t            mq [3][$];
  int                m_last = 2;
  logic              m_valid = 1'b0;
  logic [1:0]        m_src = 2'b00;
  logic [TAG_W-1:0]  m_tag = '0;
  logic [DATA_W-1:0] m_data = '0;
  logic              m_fp = 1'b0;

  // Model: pick first non-empty source after the last winner, then accept offers against pre-edge occupancy
  always @(posedge clk or posedge rst) begin : model
    bit     rdy [3];
    bit     offv [3];
    entry_t off [3];
    int     g;
    if (rst) begin
      for (int s = 0; s < 3; s++) mq[s].delete();
      m_last = 2; m_valid = 1'b0; m_src = 2'b00; m_tag = '0; m_data = '0; m_fp = 1'b0;
    end else begin
      for (int s = 0; s < 3; s++) rdy[s] = (mq[s].size() < DEPTH);
      offv[0] = alu_valid; off[0].tag = alu_tag; off[0].data = alu_data; off[0].fp = 1'b0;
      offv[1] = fpu_valid; off[1].tag = fpu_tag; off[1].data = fpu_data; off[1].fp = 1'b1;
      offv[2] = lsu_valid; off[2].tag = lsu_tag; off[2].data = lsu_data; off[2].fp = lsu_is_fp;
      m_valid = 1'b0;
      m_src   = 2'b00;
      if (flush) begin
        for (int s = 0; s < 3; s++) mq[s].delete();
      end else begin
        g = -1;
        for (int k = 1; k <= 3; k++)
          if (g < 0 && mq[(m_last + k) % 3].size() > 0) g = (m_last + k) % 3;
        if (g >= 0) begin
          entry_t e;
          e       = mq[g].pop_front();
          m_valid = 1'b1;
          m_src   = 2'(g + 1);
          m_tag   = e.tag;
          m_data  = e.data;
          m_fp    = e.fp;
          m_last  = g;
        end
        for (int s = 0; s < 3; s++)
          if (offv[s] && rdy[s]) mq[s].push_back(off[s]);
      end
    end
  end

  // Compare DUT against model on every falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("model_cdb_valid", 64'(cdb_valid), 64'(m_valid));
      checkOutput("model_cdb_src",   64'(cdb_src),   64'(m_src));
      checkOutput("model_cdb_tag",   64'(cdb_tag),   64'(m_tag));
      checkOutput("model_cdb_data",  64'(cdb_data),  64'(m_data));
      checkOutput("model_cdb_is_fp", 64'(cdb_is_fp), 64'(m_fp));
      checkOutput("model_alu_ready", 64'(alu_ready), 64'(mq[0].size() < DEPTH));
      checkOutput("model_fpu_ready", 64'(fpu_ready), 64'(mq[1].size() < DEPTH));
      checkOutput("model_lsu_ready", 64'(lsu_ready), 64'(mq[2].size() < DEPTH));
    end
  end

  // Fairness window statistics: grants per source and longest wait between grants
  bit win_en = 1'b0;
  int win_grants [3];
  int win_since [3];
  int win_valid = 0;
  int win_maxgap = 0;
  always @(negedge clk) begin
    if (win_en) begin
      for (int s = 0; s < 3; s++) win_since[s]++;
      if (cdb_valid && cdb_src != 2'b00) begin
        win_valid++;
        win_grants[int'(cdb_src) - 1]++;
        if (win_since[int'(cdb_src) - 1] > win_maxgap) win_maxgap = win_since[int'(cdb_src) - 1];
        win_since[int'(cdb_src) - 1] = 0;
      end
    end
  end

  // All three sources offer every cycle, advancing their tag on each accepted handshake
  task automatic offerAll(input int n, input logic [TAG_W-1:0] base, input int win_start);
    logic [TAG_W-1:0] ta, tf, tl;
    logic lfp, acc_a, acc_f, acc_l;
    ta = base; tf = base | 4'd1; tl = base | 4'd2; lfp = 1'b0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, ta, 32'hA000_0000 | 32'(i), 1'b1, tf, 32'hF000_0000 | 32'(i),
                    1'b1, tl, 32'hB000_0000 | 32'(i), lfp, 1'b0);
      acc_a = alu_ready; acc_f = fpu_ready; acc_l = lsu_ready;
      tick();
      if (acc_a) ta = base | ((ta + 4'd1) & 4'd7);
      if (acc_f) tf = base | ((tf + 4'd1) & 4'd7);
      if (acc_l) begin tl = base | ((tl + 4'd1) & 4'd7); lfp = ~lfp; end
      if (i == win_start - 1) win_en = 1'b1;
      if (i == win_start + 29) win_en = 1'b0;
    end
  endtask

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    int bcnt, streak, max_streak;
    bit bad_tag, saw_post;

    #1;
    doReset();
    cmp_en = 1'b1;

    // reset state
    checkOutput("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    checkOutput("reset_cdb_src",   64'(cdb_src),   64'd0);
    checkOutput("reset_cdb_tag",   64'(cdb_tag),   64'd0);
    checkOutput("reset_cdb_data",  64'(cdb_data),  64'd0);
    checkOutput("reset_ready_all", 64'({alu_ready, fpu_ready, lsu_ready}), 64'b111);

    // single ALU offer: visible one cycle after the enqueue edge, for one cycle only
    applyStimulus(1'b1, 4'd3, 32'h1234, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("single_cycle0_valid", 64'(cdb_valid), 64'd0);
    tick();
    checkOutput("single_valid", 64'(cdb_valid), 64'd1);
    checkOutput("single_src",   64'(cdb_src),   64'd1);
    checkOutput("single_tag",   64'(cdb_tag),   64'd3);
    checkOutput("single_data",  64'(cdb_data),  64'h1234);
    checkOutput("single_is_fp", 64'(cdb_is_fp), 64'd0);
    tick();
    checkOutput("single_after_valid", 64'(cdb_valid), 64'd0);
    checkOutput("single_after_src",   64'(cdb_src),   64'd0);
    checkOutput("single_hold_tag",    64'(cdb_tag),   64'd3);

    // three simultaneous offers after reset: ALU, FPU, LSU in order
    doReset();
    applyStimulus(1'b1, 4'd1, 32'h11, 1'b1, 4'd2, 32'h22, 1'b1, 4'd4, 32'h44, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("order1_src", 64'(cdb_src), 64'd1);
    checkOutput("order1_tag", 64'(cdb_tag), 64'd1);
    checkOutput("order1_fp",  64'(cdb_is_fp), 64'd0);
    tick();
    checkOutput("order2_src", 64'(cdb_src), 64'd2);
    checkOutput("order2_tag", 64'(cdb_tag), 64'd2);
    checkOutput("order2_fp",  64'(cdb_is_fp), 64'd1);
    tick();
    checkOutput("order3_src",  64'(cdb_src), 64'd3);
    checkOutput("order3_tag",  64'(cdb_tag), 64'd4);
    checkOutput("order3_data", 64'(cdb_data), 64'h44);
    checkOutput("order3_fp",   64'(cdb_is_fp), 64'd1);
    tick();
    checkOutput("order_idle_valid", 64'(cdb_valid), 64'd0);

    // ALU streaming alone: one broadcast per cycle, ready never low for long
    bcnt = 0; streak = 0; max_streak = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 4'(i), 32'h100 + 32'(i), 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      if (i >= 1 && cdb_valid) bcnt++;
      if (!alu_ready) streak++; else streak = 0;
      if (streak > max_streak) max_streak = streak;
    end
    idle();
    tick();
    if (cdb_valid) bcnt++;
    checkOutput("alu_stream_broadcasts", 64'(bcnt), 64'd20);
    checkOutput("alu_stream_ready_ok",   64'(max_streak <= 1), 64'd1);
    tick();

    // all sources saturated: 30-cycle window, 10 grants each, no gap over 3
    for (int s = 0; s < 3; s++) begin win_grants[s] = 0; win_since[s] = 0; end
    win_valid = 0; win_maxgap = 0;
    offerAll(36, 4'd0, 6);
    idle();
    for (int s = 0; s < 3; s++) if (win_since[s] > win_maxgap) win_maxgap = win_since[s];
    checkOutput("sat_valid_cycles", 64'(win_valid), 64'd30);
    checkOutput("sat_alu_grants",   64'(win_grants[0]), 64'd10);
    checkOutput("sat_fpu_grants",   64'(win_grants[1]), 64'd10);
    checkOutput("sat_lsu_grants",   64'(win_grants[2]), 64'd10);
    checkOutput("sat_gap_ok",       64'(win_maxgap <= 3), 64'd1);
    repeat (6) tick();

    // flush with queued entries (tags 8..15 mark pre-flush work)
    doReset();
    offerAll(4, 4'd8, -100);
    applyStimulus(1'b1, 4'd9, 32'hDEAD, 1'b1, 4'd10, 32'hBEEF, 1'b1, 4'd11, 32'hCAFE, 1'b0, 1'b1);
    tick();
    idle();
    checkOutput("flush_valid",     64'(cdb_valid), 64'd0);
    checkOutput("flush_ready_all", 64'({alu_ready, fpu_ready, lsu_ready}), 64'b111);
    applyStimulus(1'b1, 4'd2, 32'h2222, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    bad_tag = 1'b0; saw_post = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      idle();
      if (cdb_valid && cdb_tag[3]) bad_tag = 1'b1;
      if (cdb_valid && cdb_tag == 4'd2) saw_post = 1'b1;
    end
    checkOutput("flush_no_stale_tag", 64'(bad_tag), 64'd0);
    checkOutput("flush_post_entry",   64'(saw_post), 64'd1);

    // asynchronous reset in the middle of a burst
    offerAll(5, 4'd0, -100);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("areset_valid", 64'(cdb_valid), 64'd0);
    checkOutput("areset_src",   64'(cdb_src),   64'd0);
    checkOutput("areset_tag",   64'(cdb_tag),   64'd0);
    checkOutput("areset_data",  64'(cdb_data),  64'd0);
    checkOutput("areset_fp",    64'(cdb_is_fp), 64'd0);
    idle();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("areset_no_partial", 64'(cdb_valid), 64'd0);
    applyStimulus(1'b1, 4'd5, 32'h55, 1'b1, 4'd6, 32'h66, 1'b1, 4'd7, 32'h77, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    checkOutput("areset_first_src", 64'(cdb_src), 64'd1);
    checkOutput("areset_first_tag", 64'(cdb_tag), 64'd5);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
